control_sequencer: RTL and testbench

- Moore-style control unit for the single-bus CPU.
- Steps every instruction through fetch (T0–T2) and execute (T3–T7).
- Drives the register select/encode strobes (Gra/Grb/Grc/Rin/Rout/BAout), bus drivers, register loads, memory strobes and ALU op.
- Stalls on memory via a done handshake. Sits between the IR opcode field and the datapath.

---
 rtl/cpu_ctrl_pkg.sv | 106 ++++++++++
 rtl/ctrl_step_decoder.sv | 150 +++++++++++++++
 rtl/control_sequencer.sv | 115 +++++++++++
 tb/tb_control_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared encodings for the single-bus CPU control sequencer.
// Holds opcode values, the step/state encoding and bit positions inside the
// reg_sel, drive, load and mem strobe vectors.
package cpu_ctrl_pkg;

    // IR[31:27] opcode values
    localparam logic [4:0] OpLd   = 5'b00000;
    localparam logic [4:0] OpLdi  = 5'b00001;
    localparam logic [4:0] OpSt   = 5'b00010;
    localparam logic [4:0] OpAdd  = 5'b00011;
    localparam logic [4:0] OpSub  = 5'b00100;
    localparam logic [4:0] OpAnd  = 5'b00101;
    localparam logic [4:0] OpOr   = 5'b00110;
    localparam logic [4:0] OpAddi = 5'b01100;
    localparam logic [4:0] OpAndi = 5'b01101;
    localparam logic [4:0] OpOri  = 5'b01110;
    localparam logic [4:0] OpBr   = 5'b10010;
    localparam logic [4:0] OpJr   = 5'b10011;
    localparam logic [4:0] OpNop  = 5'b11010;
    localparam logic [4:0] OpHalt = 5'b11011;

    // State encoding doubles as the externally visible step number
    typedef enum logic [3:0] {
        StReset = 4'd0,
        StT0    = 4'd1,
        StT1    = 4'd2,
        StT2    = 4'd3,
        StT3    = 4'd4,
        StT4    = 4'd5,
        StT5    = 4'd6,
        StT6    = 4'd7,
        StT7    = 4'd8,
        StHalt  = 4'd15
    } state_e;

    // reg_sel = {Gra,Grb,Grc,Rin,Rout,BAout}
    localparam int unsigned RsGra   = 5;
    localparam int unsigned RsGrb   = 4;
    localparam int unsigned RsGrc   = 3;
    localparam int unsigned RsRin   = 2;
    localparam int unsigned RsRout  = 1;
    localparam int unsigned RsBaOut = 0;

    // drive = {PCout,Zlowout,MDRout,Cout}
    localparam int unsigned DrvPcOut   = 3;
    localparam int unsigned DrvZlowOut = 2;
    localparam int unsigned DrvMdrOut  = 1;
    localparam int unsigned DrvCOut    = 0;

    // load = {PCin,IRin,MARin,MDRin,Yin,Zin,CONin,IncPC}
    localparam int unsigned LdPcIn  = 7;
    localparam int unsigned LdIrIn  = 6;
    localparam int unsigned LdMarIn = 5;
    localparam int unsigned LdMdrIn = 4;
    localparam int unsigned LdYIn   = 3;
    localparam int unsigned LdZIn   = 2;
    localparam int unsigned LdConIn = 1;
    localparam int unsigned LdIncPc = 0;

    // mem = {Read,Write}
    localparam int unsigned MemRead  = 1;
    localparam int unsigned MemWrite = 0;

    typedef enum logic [3:0] {
        OcAluRr,
        OcAluImm,
        OcLdi,
        OcLd,
        OcSt,
        OcBr,
        OcJr,
        OcNop,
        OcHalt,
        OcIllegal
    } op_class_e;

    // Group opcodes by the execute sequence they follow
    function automatic op_class_e op_class(input logic [4:0] op);
        op_class_e oc;
        case (op)
            OpLd:                      oc = OcLd;
            OpLdi:                     oc = OcLdi;
            OpSt:                      oc = OcSt;
            OpAdd, OpSub, OpAnd, OpOr: oc = OcAluRr;
            OpAddi, OpAndi, OpOri:     oc = OcAluImm;
            OpBr:                      oc = OcBr;
            OpJr:                      oc = OcJr;
            OpNop:                     oc = OcNop;
            OpHalt:                    oc = OcHalt;
            default:                   oc = OcIllegal;
        endcase
        return oc;
    endfunction

    // Immediate forms reuse the register-register ALU operation
    function automatic logic [4:0] imm_alu_op(input logic [4:0] op);
        logic [4:0] res;
        case (op)
            OpAndi:  res = OpAnd;
            OpOri:   res = OpOr;
            default: res = OpAdd;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ctrl_step_decoder.sv
// ctrl_step_decoder: purely combinational strobe decode for the control
// sequencer. Outputs depend on state and opcode; con_ff only gates the
// branch PCin in T6, and stall_i only suppresses PCin on repeated T1 cycles.
module ctrl_step_decoder
    import cpu_ctrl_pkg::*;
#(
    parameter logic [4:0] AluAdd = 5'b00011
) (
    input  state_e     state_i,
    input  logic [4:0] opcode_i,
    input  logic       con_ff_i,
    input  logic       stall_i,
    output logic [5:0] reg_sel_o,
    output logic [3:0] drive_o,
    output logic [7:0] load_o,
    output logic [1:0] mem_o,
    output logic [4:0] alu_op_o
);

    op_class_e oc;
    assign oc = op_class(opcode_i);

    // Decode strobes for the current step
    always_comb begin
        reg_sel_o = '0;
        drive_o   = '0;
        load_o    = '0;
        mem_o     = '0;
        alu_op_o  = '0;
        unique case (state_i)
            StT0: begin
                drive_o[DrvPcOut] = 1'b1;
                load_o[LdMarIn]   = 1'b1;
                load_o[LdIncPc]   = 1'b1;
                load_o[LdZIn]     = 1'b1;
                alu_op_o          = AluAdd;
            end
            StT1: begin
                drive_o[DrvZlowOut] = 1'b1;
                load_o[LdPcIn]      = ~stall_i;  // PC update only once per fetch
                load_o[LdMdrIn]     = 1'b1;
                mem_o[MemRead]      = 1'b1;
            end
            StT2: begin
                drive_o[DrvMdrOut] = 1'b1;
                load_o[LdIrIn]     = 1'b1;
            end
            StT3: begin
                case (oc)
                    OcAluRr, OcAluImm: begin
                        reg_sel_o[RsGrb]  = 1'b1;
                        reg_sel_o[RsRout] = 1'b1;
                        load_o[LdYIn]     = 1'b1;
                    end
                    OcLdi, OcLd, OcSt: begin
                        reg_sel_o[RsGrb]   = 1'b1;
                        reg_sel_o[RsBaOut] = 1'b1;
                        load_o[LdYIn]      = 1'b1;
                    end
                    OcBr: begin
                        reg_sel_o[RsGra]  = 1'b1;
                        reg_sel_o[RsRout] = 1'b1;
                        load_o[LdConIn]   = 1'b1;
                    end
                    OcJr: begin
                        reg_sel_o[RsGra]  = 1'b1;
                        reg_sel_o[RsRout] = 1'b1;
                        load_o[LdPcIn]    = 1'b1;
                    end
                    default: ;
                endcase
            end
            StT4: begin
                case (oc)
                    OcAluRr: begin
                        reg_sel_o[RsGrc]  = 1'b1;
                        reg_sel_o[RsRout] = 1'b1;
                        load_o[LdZIn]     = 1'b1;
                        alu_op_o          = opcode_i;
                    end
                    OcAluImm: begin
                        drive_o[DrvCOut] = 1'b1;
                        load_o[LdZIn]    = 1'b1;
                        alu_op_o         = imm_alu_op(opcode_i);
                    end
                    OcLdi, OcLd, OcSt: begin
                        drive_o[DrvCOut] = 1'b1;
                        load_o[LdZIn]    = 1'b1;
                        alu_op_o         = AluAdd;
                    end
                    OcBr: begin
                        drive_o[DrvPcOut] = 1'b1;
                        load_o[LdYIn]     = 1'b1;
                    end
                    default: ;
                endcase
            end
            StT5: begin
                case (oc)
                    OcAluRr, OcAluImm, OcLdi: begin
                        drive_o[DrvZlowOut] = 1'b1;
                        reg_sel_o[RsGra]    = 1'b1;
                        reg_sel_o[RsRin]    = 1'b1;
                    end
                    OcLd, OcSt: begin
                        drive_o[DrvZlowOut] = 1'b1;
                        load_o[LdMarIn]     = 1'b1;
                    end
                    OcBr: begin
                        drive_o[DrvCOut] = 1'b1;
                        load_o[LdZIn]    = 1'b1;
                        alu_op_o         = AluAdd;
                    end
                    default: ;
                endcase
            end
            StT6: begin
                case (oc)
                    OcLd: begin
                        mem_o[MemRead]  = 1'b1;
                        load_o[LdMdrIn] = 1'b1;
                    end
                    OcSt: begin
                        reg_sel_o[RsGra]  = 1'b1;
                        reg_sel_o[RsRout] = 1'b1;
                        load_o[LdMdrIn]   = 1'b1;
                    end
                    OcBr: begin
                        drive_o[DrvZlowOut] = 1'b1;
                        load_o[LdPcIn]      = con_ff_i;
                    end
                    default: ;
                endcase
            end
            StT7: begin
                case (oc)
                    OcLd: begin
                        drive_o[DrvMdrOut] = 1'b1;
                        reg_sel_o[RsGra]   = 1'b1;
                        reg_sel_o[RsRin]   = 1'b1;
                    end
                    OcSt: mem_o[MemWrite] = 1'b1;
                    default: ;
                endcase
            end
            default: ;  // RESET and HALT drive nothing
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: Moore control unit for the single-bus CPU. Holds the
// step register, memory stall tracking and the sticky illegal-opcode flag;
// strobe decoding lives in ctrl_step_decoder.
// Build option: define CTRL_ILLEGAL_TRAP_EN to halt on an illegal opcode
// instead of treating it as nop.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter logic [4:0] ALU_ADD       = 5'b00011,
    parameter bit         HALT_ON_RESET = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] opcode,
    input  logic       con_ff,
    input  logic       mem_done,
    output logic [5:0] reg_sel,
    output logic [3:0] drive,
    output logic [7:0] load,
    output logic [1:0] mem,
    output logic [4:0] alu_op,
    output logic [3:0] step,
    output logic       run,
    output logic       illegal
);

    state_e    state_q, state_d;
    logic      stall_q, stall_d;
    logic      illegal_q, illegal_d;
    op_class_e oc;

    assign oc = op_class(opcode);

    // Next-state sequencing, memory waits and illegal-opcode capture
    always_comb begin
        state_d   = state_q;
        stall_d   = 1'b0;
        illegal_d = illegal_q;
        unique case (state_q)
            StReset: state_d = HALT_ON_RESET ? StHalt : StT0;
            StT0:    state_d = StT1;
            StT1: begin
                if (mem_done) state_d = StT2;
                else          stall_d = 1'b1;
            end
            StT2:    state_d = StT3;
            StT3: begin
                case (oc)
                    OcHalt:       state_d = StHalt;
                    OcJr, OcNop:  state_d = StT0;
                    OcIllegal: begin
                        illegal_d = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
                        state_d   = StHalt;
`else
                        state_d   = StT0;
`endif
                    end
                    default:      state_d = StT4;
                endcase
            end
            StT4:    state_d = StT5;
            StT5: begin
                case (oc)
                    OcLd, OcSt, OcBr: state_d = StT6;
                    default:          state_d = StT0;
                endcase
            end
            StT6: begin
                case (oc)
                    OcLd:    if (mem_done) state_d = StT7;
                    OcSt:    state_d = StT7;
                    default: state_d = StT0;
                endcase
            end
            StT7: begin
                if (oc != OcSt || mem_done) state_d = StT0;
            end
            StHalt:  state_d = StHalt;
            default: state_d = StReset;
        endcase
    end

    // State register; reset aborts any wait and clears the sticky flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StReset;
            stall_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            stall_q   <= stall_d;
            illegal_q <= illegal_d;
        end
    end

    ctrl_step_decoder #(
        .AluAdd (ALU_ADD)
    ) u_decoder (
        .state_i   (state_q),
        .opcode_i  (opcode),
        .con_ff_i  (con_ff),
        .stall_i   (stall_q),
        .reg_sel_o (reg_sel),
        .drive_o   (drive),
        .load_o    (load),
        .mem_o     (mem),
        .alu_op_o  (alu_op)
    );

    assign step    = state_q;
    assign run     = (state_q != StReset) && (state_q != StHalt);
    assign illegal = illegal_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: table-driven check of the control sequencer through
// complete instruction traces, plus hand sequences for async reset cases.
module tb_control_sequencer;

    logic       clock;
    logic       reset;
    logic [4:0] opcode;
    logic       con_ff;
    logic       mem_done;
    logic [5:0] reg_sel;
    logic [3:0] drive;
    logic [7:0] load;
    logic [1:0] mem;
    logic [4:0] alu_op;
    logic [3:0] step;
    logic       run;
    logic       illegal;

    int checks = 0;
    int errors = 0;

    control_sequencer dut (
        .clock    (clock),
        .reset    (reset),
        .opcode   (opcode),
        .con_ff   (con_ff),
        .mem_done (mem_done),
        .reg_sel  (reg_sel),
        .drive    (drive),
        .load     (load),
        .mem      (mem),
        .alu_op   (alu_op),
        .step     (step),
        .run      (run),
        .illegal  (illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // exp = {step, reg_sel, drive, load, mem, alu_op, run, illegal}
    typedef struct {
        logic [4:0]  op;
        logic        cff;
        logic        md;
        logic [30:0] exp;
    } vec_t;

    vec_t vq[$];

    localparam logic [4:0] OLd   = 5'b00000;
    localparam logic [4:0] OLdi  = 5'b00001;
    localparam logic [4:0] OSt   = 5'b00010;
    localparam logic [4:0] OAdd  = 5'b00011;
    localparam logic [4:0] OSub  = 5'b00100;
    localparam logic [4:0] OAndi = 5'b01101;
    localparam logic [4:0] OBr   = 5'b10010;
    localparam logic [4:0] OJr   = 5'b10011;
    localparam logic [4:0] ONop  = 5'b11010;
    localparam logic [4:0] OHalt = 5'b11011;
    localparam logic [4:0] OBad  = 5'b11111;

    function automatic logic [30:0] outs();
        return {step, reg_sel, drive, load, mem, alu_op, run, illegal};
    endfunction

    task automatic check(input string name, input logic [30:0] got, input logic [30:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic v(input logic [4:0] op, input logic cff, input logic md,
                     input logic [3:0] st, input logic [5:0] rs, input logic [3:0] drv,
                     input logic [7:0] ld, input logic [1:0] mm, input logic [4:0] alu,
                     input logic rn, input logic il);
        vec_t x;
        x.op  = op;
        x.cff = cff;
        x.md  = md;
        x.exp = {st, rs, drv, ld, mm, alu, rn, il};
        vq.push_back(x);
    endtask

    // T0..T2 with nstall extra cycles of mem_done low in T1
    task automatic fetch(input logic [4:0] op, input logic cff, input logic il,
                         input int nstall);
        v(op, cff, 1'b1, 4'd1, '0, 4'b1000, 8'b00100101, '0, 5'b00011, 1'b1, il);
        if (nstall == 0) begin
            v(op, cff, 1'b1, 4'd2, '0, 4'b0100, 8'b10010000, 2'b10, '0, 1'b1, il);
        end else begin
            v(op, cff, 1'b0, 4'd2, '0, 4'b0100, 8'b10010000, 2'b10, '0, 1'b1, il);
            for (int k = 1; k < nstall; k++)
                v(op, cff, 1'b0, 4'd2, '0, 4'b0100, 8'b00010000, 2'b10, '0, 1'b1, il);
            v(op, cff, 1'b1, 4'd2, '0, 4'b0100, 8'b00010000, 2'b10, '0, 1'b1, il);
        end
        v(op, cff, 1'b1, 4'd3, '0, 4'b0010, 8'b01000000, '0, '0, 1'b1, il);
    endtask

    // T3..T5 shared by ldi, ld and st
    task automatic addr_calc(input logic [4:0] op);
        v(op, 1'b0, 1'b1, 4'd4, 6'b010001, '0, 8'b00001000, '0, '0, 1'b1, 1'b0);
        v(op, 1'b0, 1'b1, 4'd5, '0, 4'b0001, 8'b00000100, '0, 5'b00011, 1'b1, 1'b0);
    endtask

    task automatic br_seq(input logic cff);
        fetch(OBr, cff, 1'b0, 0);
        v(OBr, cff, 1'b1, 4'd4, 6'b100010, '0, 8'b00000010, '0, '0, 1'b1, 1'b0);
        v(OBr, cff, 1'b1, 4'd5, '0, 4'b1000, 8'b00001000, '0, '0, 1'b1, 1'b0);
        v(OBr, cff, 1'b1, 4'd6, '0, 4'b0001, 8'b00000100, '0, 5'b00011, 1'b1, 1'b0);
        v(OBr, cff, 1'b1, 4'd7, '0, 4'b0100, {cff, 7'b0}, '0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        reset    = 1'b1;
        opcode   = '0;
        con_ff   = 1'b0;
        mem_done = 1'b1;

        // RESET state before release
        v(OAdd, 1'b0, 1'b1, 4'd0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
        // add r1,r2,r3
        fetch(OAdd, 1'b0, 1'b0, 0);
        v(OAdd, 1'b0, 1'b1, 4'd4, 6'b010010, '0, 8'b00001000, '0, '0, 1'b1, 1'b0);
        v(OAdd, 1'b0, 1'b1, 4'd5, 6'b001010, '0, 8'b00000100, '0, 5'b00011, 1'b1, 1'b0);
        v(OAdd, 1'b0, 1'b1, 4'd6, 6'b100100, 4'b0100, '0, '0, '0, 1'b1, 1'b0);
        // sub with a one-cycle fetch stall
        fetch(OSub, 1'b0, 1'b0, 1);
        v(OSub, 1'b0, 1'b1, 4'd4, 6'b010010, '0, 8'b00001000, '0, '0, 1'b1, 1'b0);
        v(OSub, 1'b0, 1'b1, 4'd5, 6'b001010, '0, 8'b00000100, '0, 5'b00100, 1'b1, 1'b0);
        v(OSub, 1'b0, 1'b1, 4'd6, 6'b100100, 4'b0100, '0, '0, '0, 1'b1, 1'b0);
        // andi uses the AND ALU op
        fetch(OAndi, 1'b0, 1'b0, 0);
        v(OAndi, 1'b0, 1'b1, 4'd4, 6'b010010, '0, 8'b00001000, '0, '0, 1'b1, 1'b0);
        v(OAndi, 1'b0, 1'b1, 4'd5, '0, 4'b0001, 8'b00000100, '0, 5'b00101, 1'b1, 1'b0);
        v(OAndi, 1'b0, 1'b1, 4'd6, 6'b100100, 4'b0100, '0, '0, '0, 1'b1, 1'b0);
        // ldi
        fetch(OLdi, 1'b0, 1'b0, 0);
        addr_calc(OLdi);
        v(OLdi, 1'b0, 1'b1, 4'd6, 6'b100100, 4'b0100, '0, '0, '0, 1'b1, 1'b0);
        // ld with a two-cycle fetch stall and three-cycle T6 wait
        fetch(OLd, 1'b0, 1'b0, 2);
        addr_calc(OLd);
        v(OLd, 1'b0, 1'b1, 4'd6, '0, 4'b0100, 8'b00100000, '0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++)
            v(OLd, 1'b0, 1'b0, 4'd7, '0, '0, 8'b00010000, 2'b10, '0, 1'b1, 1'b0);
        v(OLd, 1'b0, 1'b1, 4'd7, '0, '0, 8'b00010000, 2'b10, '0, 1'b1, 1'b0);
        v(OLd, 1'b0, 1'b1, 4'd8, 6'b100100, 4'b0010, '0, '0, '0, 1'b1, 1'b0);
        // st with a two-cycle T7 wait
        fetch(OSt, 1'b0, 1'b0, 0);
        addr_calc(OSt);
        v(OSt, 1'b0, 1'b1, 4'd6, '0, 4'b0100, 8'b00100000, '0, '0, 1'b1, 1'b0);
        v(OSt, 1'b0, 1'b1, 4'd7, 6'b100010, '0, 8'b00010000, '0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++)
            v(OSt, 1'b0, 1'b0, 4'd8, '0, '0, '0, 2'b01, '0, 1'b1, 1'b0);
        v(OSt, 1'b0, 1'b1, 4'd8, '0, '0, '0, 2'b01, '0, 1'b1, 1'b0);
        // branch not taken, then taken
        br_seq(1'b0);
        br_seq(1'b1);
        // jr
        fetch(OJr, 1'b0, 1'b0, 0);
        v(OJr, 1'b0, 1'b1, 4'd4, 6'b100010, '0, 8'b10000000, '0, '0, 1'b1, 1'b0);
        // nop
        fetch(ONop, 1'b0, 1'b0, 0);
        v(ONop, 1'b0, 1'b1, 4'd4, '0, '0, '0, '0, '0, 1'b1, 1'b0);
        // illegal opcode
        fetch(OBad, 1'b0, 1'b0, 0);
        v(OBad, 1'b0, 1'b1, 4'd4, '0, '0, '0, '0, '0, 1'b1, 1'b0);
`ifdef CTRL_ILLEGAL_TRAP_EN
        for (int k = 0; k < 3; k++)
            v(OBad, 1'b0, 1'b1, 4'd15, '0, '0, '0, '0, '0, 1'b0, 1'b1);
`else
        // continues as nop with the sticky flag set, then halts
        fetch(OHalt, 1'b0, 1'b1, 0);
        v(OHalt, 1'b0, 1'b1, 4'd4, '0, '0, '0, '0, '0, 1'b1, 1'b1);
        for (int k = 0; k < 20; k++)
            v(OHalt, k[0], 1'b1, 4'd15, '0, '0, '0, '0, '0, 1'b0, 1'b1);
`endif

        // Reset state while reset is held
        @(negedge clock);
        check("reset_held", outs(), '0);
        @(posedge clock);
        #1 reset = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            opcode   = vq[i].op;
            con_ff   = vq[i].cff;
            mem_done = vq[i].md;
            @(negedge clock);
            check($sformatf("vec%0d", i), outs(), vq[i].exp);
            check($sformatf("vec%0d_one_driver", i), {30'b0, $countones(drive) <= 1}, 31'd1);
            check($sformatf("vec%0d_rw_excl", i), {30'b0, mem != 2'b11}, 31'd1);
            @(posedge clock);
            #1;
        end

        // Reset pulse out of HALT clears everything at once, then fetch resumes
        #1 reset = 1'b1;
        #1 check("halt_async_reset", outs(), '0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("after_release_reset", outs(), '0);
        @(posedge clock);
        #1;
        @(negedge clock);
        check("after_release_t0", outs(),
              {4'd1, 6'b0, 4'b1000, 8'b00100101, 2'b00, 5'b00011, 1'b1, 1'b0});

        // st stuck in T7 wait, then reset mid-cycle
        opcode   = OSt;
        mem_done = 1'b1;
        repeat (3) @(posedge clock);
        #1 mem_done = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        check("st_t7_wait", outs(), {4'd8, 6'b0, 4'b0, 8'b0, 2'b01, 5'b0, 1'b1, 1'b0});
        @(posedge clock);
        #1;
        check("st_t7_still_waiting", outs(), {4'd8, 6'b0, 4'b0, 8'b0, 2'b01, 5'b0, 1'b1, 1'b0});
        #1 reset = 1'b1;
        #1 check("st_abort_write", {29'b0, mem}, '0);
        check("st_abort_all", outs(), '0);
        @(posedge clock);
        #1 reset = 1'b0;
        mem_done = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
